// File: rtl/clock_module_gate_multi.sv
// Shared clock-gate slice: aggregates child requests, sequences parent and gate handshakes.
// Optional ack watchdog enabled by defining CLOCK_MODULE_GATE_ACK_TIMEOUT_EN.
module clock_module_gate_multi #(
    parameter int unsigned CHILD_COUNT = 4,
    parameter int unsigned STOP_DELAY  = 16,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                   clock,
    input  logic                   sync_reset,
    output logic                   parent_request,
    input  logic                   parent_ready,
    input  logic                   parent_silent,
    input  logic                   parent_starting,
    input  logic                   parent_stopping,
    input  logic [CHILD_COUNT-1:0] child_request,
    output logic [CHILD_COUNT-1:0] child_ready,
    output logic                   child_silent,
    output logic                   child_starting,
    output logic                   child_stopping,
    output logic                   async_enable,
    input  logic                   async_enable_ack,
    output logic                   ack_timeout_error
);

    localparam int unsigned IdleW = (STOP_DELAY > 0) ? $clog2(STOP_DELAY + 1) : 1;
    localparam logic [IdleW-1:0] IdleMax = IdleW'(STOP_DELAY);

    typedef enum logic [2:0] {
        StOff,
        StParentWait,
        StEnabling,
        StOn,
        StHold,
        StDisabling,
        StRelease
    } state_e;

    state_e           state_q, state_d;
    logic             ack_meta_q, ack_s_q;
    logic [IdleW-1:0] idle_q, idle_d, idle_inc;
    logic             any_req;
    logic             to_expired;

    // Parent status inputs are informational only.
    logic unused_inputs;
    assign unused_inputs = ^{parent_starting, parent_stopping, (ACK_TIMEOUT == 0)};

    assign any_req  = |child_request;
    assign idle_inc = (idle_q == IdleMax) ? idle_q : idle_q + IdleW'(1);

    always_comb begin
        state_d = state_q;
        idle_d  = '0;
        unique case (state_q)
            StOff: begin
                if (any_req) state_d = StParentWait;
            end
            StParentWait: begin
                if (parent_ready) state_d = StEnabling;
            end
            StEnabling: begin
                if (ack_s_q || to_expired) state_d = StOn;
            end
            StOn: begin
                if (!parent_ready) begin
                    state_d = StDisabling;
                end else if (!any_req) begin
                    state_d = (STOP_DELAY == 0) ? StDisabling : StHold;
                end
            end
            StHold: begin
                // A returning request keeps the gate open and restarts the idle count.
                if (!parent_ready) begin
                    state_d = StDisabling;
                end else if (any_req) begin
                    state_d = StOn;
                end else if (idle_inc == IdleMax) begin
                    state_d = StDisabling;
                end else begin
                    idle_d = idle_inc;
                end
            end
            StDisabling: begin
                if (!ack_s_q || to_expired) state_d = StRelease;
            end
            StRelease: begin
                if (parent_silent) state_d = StOff;
            end
            default: state_d = StOff;
        endcase
    end

`ifdef CLOCK_MODULE_GATE_ACK_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(ACK_TIMEOUT + 2);
    localparam logic [ToW-1:0] ToLimit = ToW'(ACK_TIMEOUT);

    logic [ToW-1:0] to_q, to_d;
    logic           err_q;

    assign to_expired = (state_q == StEnabling || state_q == StDisabling) && (to_q >= ToLimit);

    always_comb begin
        to_d = '0;
        if ((state_q == StEnabling || state_q == StDisabling) && state_d == state_q) begin
            to_d = (to_q > ToLimit) ? to_q : to_q + ToW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (sync_reset) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            to_q <= to_d;
            if (to_expired) err_q <= 1'b1;
        end
    end

    assign ack_timeout_error = err_q;
`else
    assign to_expired        = 1'b0;
    assign ack_timeout_error = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (sync_reset) begin
            state_q        <= StOff;
            ack_meta_q     <= 1'b0;
            ack_s_q        <= 1'b0;
            idle_q         <= '0;
            parent_request <= 1'b0;
            async_enable   <= 1'b0;
            child_silent   <= 1'b1;
            child_starting <= 1'b0;
            child_stopping <= 1'b0;
        end else begin
            state_q        <= state_d;
            ack_meta_q     <= async_enable_ack;
            ack_s_q        <= ack_meta_q;
            idle_q         <= idle_d;
            // Outputs are registered from next state so they line up with state_q.
            parent_request <= (state_d == StParentWait) || (state_d == StEnabling) ||
                              (state_d == StOn) || (state_d == StHold) ||
                              (state_d == StDisabling);
            async_enable   <= (state_d == StEnabling) || (state_d == StOn) ||
                              (state_d == StHold);
            child_silent   <= (state_d == StOff);
            child_starting <= (state_d == StParentWait) || (state_d == StEnabling);
            child_stopping <= (state_d == StDisabling) || (state_d == StRelease);
        end
    end

    assign child_ready = {CHILD_COUNT{(state_q == StOn) || (state_q == StHold)}} & child_request;

endmodule

// File: tb/tb_clock_module_gate_multi.sv
// Directed bench for clock_module_gate_multi: vector table for start-up, hand sequences
// for idle hold, stop, no-abort restart, forced stop, mid-operation reset and ack timeout.
module tb_clock_module_gate_multi;

    logic       clock = 1'b0;
    logic       sync_reset;
    logic       parent_request, parent_ready, parent_silent;
    logic       parent_starting, parent_stopping;
    logic [3:0] child_request, child_ready;
    logic       child_silent, child_starting, child_stopping;
    logic       async_enable, async_enable_ack, ack_timeout_error;
    logic       ack_follow, ack_force;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    // Instant-ack hard macro model, or a forced level for timeout tests.
    assign async_enable_ack = ack_follow ? async_enable : ack_force;

    clock_module_gate_multi #(
        .CHILD_COUNT(4),
        .STOP_DELAY (16),
        .ACK_TIMEOUT(8)
    ) dut (
        .clock            (clock),
        .sync_reset       (sync_reset),
        .parent_request   (parent_request),
        .parent_ready     (parent_ready),
        .parent_silent    (parent_silent),
        .parent_starting  (parent_starting),
        .parent_stopping  (parent_stopping),
        .child_request    (child_request),
        .child_ready      (child_ready),
        .child_silent     (child_silent),
        .child_starting   (child_starting),
        .child_stopping   (child_stopping),
        .async_enable     (async_enable),
        .async_enable_ack (async_enable_ack),
        .ack_timeout_error(ack_timeout_error)
    );

    typedef struct {
        string      name;
        logic [3:0] req;
        logic       pr;
        logic       ps;
        logic [9:0] exp;
    } vec_t;

    localparam int SOff = 0, SPw = 1, SEn = 2, SOn = 3, SDis = 4, SRel = 5;

    // Packed as {parent_request, async_enable, child_ready, silent, starting, stopping, error}.
    function automatic logic [9:0] ex(input int s, input logic [3:0] rdy, input logic err);
        logic [9:0] r;
        case (s)
            SOff:    r = {1'b0, 1'b0, 4'b0, 1'b1, 1'b0, 1'b0, err};
            SPw:     r = {1'b1, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0, err};
            SEn:     r = {1'b1, 1'b1, 4'b0, 1'b0, 1'b1, 1'b0, err};
            SOn:     r = {1'b1, 1'b1, rdy,  1'b0, 1'b0, 1'b0, err};
            SDis:    r = {1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, err};
            default: r = {1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, err};
        endcase
        return r;
    endfunction

    function automatic vec_t mk(input string n, input logic [3:0] req, input logic pr,
                                input logic ps, input logic [9:0] e);
        vec_t v;
        v.name = n;
        v.req  = req;
        v.pr   = pr;
        v.ps   = ps;
        v.exp  = e;
        return v;
    endfunction

    logic [9:0] got;
    assign got = {parent_request, async_enable, child_ready, child_silent, child_starting,
                  child_stopping, ack_timeout_error};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [9:0] e);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, e);
        end
    endtask

    task automatic apply(input vec_t v);
        child_request = v.req;
        parent_ready  = v.pr;
        parent_silent = v.ps;
        step();
        check(v.name, v.exp);
    endtask

    // Drops all requests and counts cycles until async_enable falls.
    task automatic measure_stop(input string name);
        int n;
        n = 41;
        child_request = 4'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (!async_enable) begin
                n = k;
                break;
            end
        end
        checks++;
        if (n != 17) begin
            errors++;
            $display("FAIL %s: disable after %0d cycles expected 17", name, n);
        end
    endtask

    vec_t start_tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        start_tbl[0] = mk("idle_off",    4'b0000, 1'b1, 1'b1, ex(SOff, 4'b0, 1'b0));
        start_tbl[1] = mk("parent_wait", 4'b0010, 1'b1, 1'b1, ex(SPw,  4'b0, 1'b0));
        start_tbl[2] = mk("enabling_1",  4'b0010, 1'b1, 1'b1, ex(SEn,  4'b0, 1'b0));
        start_tbl[3] = mk("enabling_2",  4'b0010, 1'b1, 1'b1, ex(SEn,  4'b0, 1'b0));
        start_tbl[4] = mk("enabling_3",  4'b0010, 1'b1, 1'b1, ex(SEn,  4'b0, 1'b0));
        start_tbl[5] = mk("on_cycle5",   4'b0010, 1'b1, 1'b1, ex(SOn,  4'b0010, 1'b0));
        start_tbl[6] = mk("on_two_reqs", 4'b1010, 1'b1, 1'b1, ex(SOn,  4'b1010, 1'b0));
        start_tbl[7] = mk("ready_drop",  4'b1000, 1'b1, 1'b1, ex(SOn,  4'b1000, 1'b0));

        parent_starting = 1'b0;
        parent_stopping = 1'b0;
        ack_follow      = 1'b1;
        ack_force       = 1'b0;
        child_request   = 4'b0;
        parent_ready    = 1'b1;
        parent_silent   = 1'b1;
        sync_reset      = 1'b1;
        step();
        step();
        check("reset", ex(SOff, 4'b0, 1'b0));
        sync_reset = 1'b0;

        foreach (start_tbl[i]) apply(start_tbl[i]);

        // Idle for 10 cycles, then a request returns without toggling the gate.
        for (int k = 0; k < 10; k++) apply(mk("hold_idle", 4'b0, 1'b1, 1'b1, ex(SOn, 4'b0, 1'b0)));
        apply(mk("hold_return", 4'b0001, 1'b1, 1'b1, ex(SOn, 4'b0001, 1'b0)));

        // Full delay again proves the idle counter was cleared.
        measure_stop("stop_delay_a");
        check("disabling_a", ex(SDis, 4'b0, 1'b0));
        apply(mk("dis_sync_1", 4'b0, 1'b1, 1'b0, ex(SDis, 4'b0, 1'b0)));
        apply(mk("dis_sync_2", 4'b0, 1'b1, 1'b0, ex(SDis, 4'b0, 1'b0)));
        apply(mk("release",    4'b0, 1'b1, 1'b0, ex(SRel, 4'b0, 1'b0)));
        apply(mk("release_wt", 4'b0, 1'b1, 1'b0, ex(SRel, 4'b0, 1'b0)));
        apply(mk("off_silent", 4'b0, 1'b1, 1'b1, ex(SOff, 4'b0, 1'b0)));

        // No abort: a request during DISABLING lets the stop finish first.
        apply(mk("b_pw",   4'b0100, 1'b1, 1'b1, ex(SPw, 4'b0, 1'b0)));
        apply(mk("b_en1",  4'b0100, 1'b1, 1'b1, ex(SEn, 4'b0, 1'b0)));
        apply(mk("b_en2",  4'b0100, 1'b1, 1'b1, ex(SEn, 4'b0, 1'b0)));
        apply(mk("b_en3",  4'b0100, 1'b1, 1'b1, ex(SEn, 4'b0, 1'b0)));
        apply(mk("b_on",   4'b0100, 1'b1, 1'b1, ex(SOn, 4'b0100, 1'b0)));
        measure_stop("stop_delay_b");
        apply(mk("noabort_dis1", 4'b0100, 1'b1, 1'b1, ex(SDis, 4'b0, 1'b0)));
        apply(mk("noabort_dis2", 4'b0100, 1'b1, 1'b1, ex(SDis, 4'b0, 1'b0)));
        apply(mk("noabort_rel",  4'b0100, 1'b1, 1'b1, ex(SRel, 4'b0, 1'b0)));
        apply(mk("silent_pulse", 4'b0100, 1'b1, 1'b1, ex(SOff, 4'b0, 1'b0)));
        apply(mk("restart",      4'b0100, 1'b1, 1'b1, ex(SPw,  4'b0, 1'b0)));

        // Forced stop when the parent clock drops while ON.
        apply(mk("c_en1", 4'b0100, 1'b1, 1'b1, ex(SEn, 4'b0, 1'b0)));
        apply(mk("c_en2", 4'b0100, 1'b1, 1'b1, ex(SEn, 4'b0, 1'b0)));
        apply(mk("c_en3", 4'b0100, 1'b1, 1'b1, ex(SEn, 4'b0, 1'b0)));
        apply(mk("c_on",  4'b0100, 1'b1, 1'b1, ex(SOn, 4'b0100, 1'b0)));
        apply(mk("forced_stop", 4'b0100, 1'b0, 1'b1, ex(SDis, 4'b0, 1'b0)));

        // Reset mid-operation drops parent_request with no release phase.
        sync_reset = 1'b1;
        apply(mk("mid_reset", 4'b0, 1'b1, 1'b1, ex(SOff, 4'b0, 1'b0)));
        sync_reset = 1'b0;

        // Ack never arrives.
        ack_follow = 1'b0;
        ack_force  = 1'b0;
        apply(mk("d_pw", 4'b0001, 1'b1, 1'b1, ex(SPw, 4'b0, 1'b0)));
        apply(mk("d_en", 4'b0001, 1'b1, 1'b1, ex(SEn, 4'b0, 1'b0)));
        for (int k = 0; k < 8; k++) apply(mk("d_en_wait", 4'b0001, 1'b1, 1'b1, ex(SEn, 4'b0, 1'b0)));
`ifdef CLOCK_MODULE_GATE_ACK_TIMEOUT_EN
        apply(mk("ack_timeout", 4'b0001, 1'b1, 1'b1, ex(SOn, 4'b0001, 1'b1)));
        apply(mk("err_sticky",  4'b0001, 1'b1, 1'b1, ex(SOn, 4'b0001, 1'b1)));
        sync_reset = 1'b1;
        apply(mk("err_reset", 4'b0, 1'b1, 1'b1, ex(SOff, 4'b0, 1'b0)));
        sync_reset = 1'b0;
`else
        for (int k = 0; k < 10; k++) apply(mk("no_timeout", 4'b0001, 1'b1, 1'b1, ex(SEn, 4'b0, 1'b0)));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_module_gate_multi.md
# clock_module_gate_multi

Parametrised clock-gate module for the clock tree: one hard-macro gate slice shared by `CHILD_COUNT` child consumers. It aggregates child requests into a single upstream request and sequences the parent handshake and the gate enable/ack handshake. It holds the clock for a programmable idle delay before gating, then reports per-child ready and broadcast status.

## Interface
Parameters:
- `CHILD_COUNT`, default 4: number of child request channels; must be at least 1.
- `STOP_DELAY`, default 16: idle cycles with no child request before the stop sequence begins; 0 means stop immediately.
- `ACK_TIMEOUT`, default 255: maximum cycles to wait for synced `async_enable_ack` to match `async_enable`. Used only with the macro in Configuration.

Ports:
- `clock`  in  1  block clock.
- `sync_reset`  in  1  synchronous, active-high reset.
- `parent_request`  out  1  upstream clock request.
- `parent_ready`  in  1  parent clock running.
- `parent_silent`  in  1  parent fully stopped.
- `parent_starting`  in  1  parent status, informational; ignored by the FSM.
- `parent_stopping`  in  1  parent status, informational; ignored by the FSM.
- `child_request`  in  CHILD_COUNT  per-child request.
- `child_ready`  out  CHILD_COUNT  per-child grant; clock is running and that child is requesting.
- `child_silent`  out  1  gate off, parent released.
- `child_starting`  out  1  start sequence in progress.
- `child_stopping`  out  1  stop sequence in progress.
- `async_enable`  out  1  gate enable to the hard macro.
- `async_enable_ack`  in  1  asynchronous ack from the hard macro; synchronised internally through 2 flops.
- `ack_timeout_error`  out  1  sticky error flag; cleared only by reset.

## Operation
- `any_req` = OR of all `child_request` bits. `ack_s` = 2-flop synchronised `async_enable_ack`.
- FSM states and transitions:
  - **OFF**: go to PARENT_WAIT when `any_req`.
  - **PARENT_WAIT**: `parent_request`=1. Go to ENABLING when `parent_ready`.
  - **ENABLING**: `async_enable`=1. Go to ON when `ack_s`=1.
  - **ON**: go to HOLD when `!any_req` and `STOP_DELAY>0`. Go to DISABLING when `!any_req` and `STOP_DELAY==0`.
  - **HOLD**: idle counter increments each cycle. If `any_req` returns, go back to ON and clear the counter; the gate is not toggled. When the counter reaches `STOP_DELAY`, go to DISABLING.
  - **DISABLING**: `async_enable`=0. Go to RELEASE when `ack_s`=0.
  - **RELEASE**: `parent_request`=0. Go to OFF when `parent_silent`.
- Forced stop: `parent_ready` falling while in ON or HOLD causes an immediate transition to DISABLING.
- No abort: a request arriving during DISABLING or RELEASE does not cancel the stop. The sequence completes to OFF, and the pending request restarts from OFF on the next cycle.
- `parent_request` is 1 in PARENT_WAIT, ENABLING, ON, HOLD and DISABLING.
- `async_enable` is 1 in ENABLING, ON and HOLD.
- `child_ready[i]` = (state is ON or HOLD) & `child_request[i]`.
- Status outputs:
  - `child_silent` = (state is OFF).
  - `child_starting` = (state is PARENT_WAIT or ENABLING).
  - `child_stopping` = (state is DISABLING or RELEASE).
- Idle counter width is `$clog2(STOP_DELAY+1)`; it saturates and never wraps.

## Timing
- All outputs are registered, except `child_ready`, which is a combinational AND of the state register with `child_request`.
- Reset values: `parent_request`=0, `async_enable`=0, `child_ready`=0, `child_silent`=1, `child_starting`=0, `child_stopping`=0, `ack_timeout_error`=0. The sync flops and all counters are cleared.
- A reset asserted mid-operation forces OFF at the next edge. `async_enable` and `parent_request` drop that same edge, without running a stop sequence.
- Start latency, with `parent_ready` present on entry and ack instant: request in cycle 0 → PARENT_WAIT@1 → ENABLING@2 → `ack_s` high @4 → ON@5; `child_ready` is asserted in cycle 5.
- Stop latency: the last request drops in cycle 0 → HOLD@1 → DISABLING@`STOP_DELAY`+1 → RELEASE after a further 2-cycle sync delay. OFF follows once `parent_silent` is seen.
- `child_ready` drops in the same cycle that its own request drops.

## Configuration
- `CLOCK_MODULE_GATE_ACK_TIMEOUT_EN` defined:
  - A counter runs in ENABLING and DISABLING.
  - If it exceeds `ACK_TIMEOUT`, `ack_timeout_error` is set (sticky).
  - The FSM proceeds as if the ack had arrived: ENABLING goes to ON, DISABLING goes to RELEASE.
- Macro undefined:
  - No counter is implemented; `ack_timeout_error` is tied to 0.
  - The FSM waits indefinitely for the ack.

## Test plan
- Reset, then `child_request`=4'b0010, parent ready and ack instant → `child_ready`=4'b0010 at cycle 5; all other bits stay 0.
- `STOP_DELAY`=16; drop all requests, re-raise one at idle cycle 10 → `async_enable` stays 1, state returns to ON, counter is cleared.
- Drop all requests and hold idle → `async_enable` falls at cycle 17, then `parent_request` falls, then `child_silent`=1 after `parent_silent`.
- Raise a request during DISABLING → stop sequence completes, `child_silent` pulses for 1 cycle, restart begins the following cycle.
- Drop `parent_ready` while ON → DISABLING next cycle and `child_ready` goes to 0.
- With the macro defined, `ACK_TIMEOUT`=8 and ack tied to 0 → `ack_timeout_error`=1 after 9 cycles in ENABLING, state goes to ON. Without the macro, the FSM stays in ENABLING and the error remains 0.
